// File: rtl/dig_ct_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dig_ct_lut_pipe
// Brief    : Multi-channel LUT logic block. Each channel evaluates a
//            runtime-writable truth table over a shared input bus. Results
//            travel through a valid-qualified pipeline, and saturating
//            counters track rising edges on each output channel.
// Revision : 1.0 - initial release
// ============================================================================
module dig_ct_lut_pipe #(
    parameter int                        CH       = 3,
    parameter int                        NIN      = 5,
    parameter int                        DEPTH    = 1,
    parameter int                        CNT_W    = 8,
    parameter logic [CH*(2**NIN)-1:0]    LUT_INIT = {32'hFFFFF0FF, 32'h3F3F3F3F, 32'hEFEFEFEF},
    localparam int                       CSW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NIN-1:0]        IN,
    input  logic                  IN_VALID,
    input  logic                  CFG_WE,
    input  logic [CSW-1:0]        CFG_SEL,
    input  logic [(2**NIN)-1:0]   CFG_DATA,
    input  logic                  CNT_CLR,
    output logic [CH-1:0]         OUT,
    output logic                  OUT_VALID,
    output logic [CH*CNT_W-1:0]   RISE_CNT
);

    localparam int               c_LUT_SZ  = 2**NIN;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Per-channel truth tables
    logic [c_LUT_SZ-1:0] r_lut [CH];

    // Combinational function outputs for the current input bus
    logic [CH-1:0] w_f;

    // Data and valid presented to the last pipeline stage at this edge
    logic [CH-1:0] w_last_d;
    logic          w_last_ld;
    logic [CH-1:0] w_rise;

    // LUT storage: reset to LUT_INIT, rewritten by the config port when the
    // selected channel exists; out-of-range selects match no channel.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < CH; c++) begin
                r_lut[c] <= LUT_INIT[c*c_LUT_SZ +: c_LUT_SZ];
            end
        end else if (CFG_WE) begin
            for (int c = 0; c < CH; c++) begin
                if (CFG_SEL == CSW'(c)) begin
                    r_lut[c] <= CFG_DATA;
                end
            end
        end
    end

    // Table lookup: each channel indexes its LUT with the raw input bus
    always_comb begin
        w_f = '0;
        for (int c = 0; c < CH; c++) begin
            w_f[c] = r_lut[c][IN];
        end
    end

    // Pipeline: stage 0 samples the LUT outputs, later stages shift.
    // Valid bits move every cycle; data only loads behind a valid bit, so a
    // bubble leaves the previous result in place.
    genvar gs;
    generate
        for (gs = 0; gs < DEPTH; gs++) begin : g_stage
            logic [CH-1:0] w_d_in;
            logic          w_v_in;
            logic [CH-1:0] r_d;
            logic          r_v;

            if (gs == 0) begin : g_first
                assign w_d_in = w_f;
                assign w_v_in = IN_VALID;
            end else begin : g_next
                assign w_d_in = g_stage[gs-1].r_d;
                assign w_v_in = g_stage[gs-1].r_v;
            end

            // Stage register with valid-qualified data load
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_d <= '0;
                    r_v <= 1'b0;
                end else begin
                    r_v <= w_v_in;
                    if (w_v_in) begin
                        r_d <= w_d_in;
                    end
                end
            end
        end
    endgenerate

    assign OUT       = g_stage[DEPTH-1].r_d;
    assign OUT_VALID = g_stage[DEPTH-1].r_v;
    assign w_last_d  = g_stage[DEPTH-1].w_d_in;
    assign w_last_ld = g_stage[DEPTH-1].w_v_in;

    // A rise is a 0->1 transition on a channel caused by the last stage loading
    assign w_rise = w_last_ld ? (w_last_d & ~OUT) : '0;

    genvar gc;
    generate
        for (gc = 0; gc < CH; gc++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // Saturating rise counter; clear wins over a same-edge increment
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_cnt <= '0;
                end else if (CNT_CLR) begin
                    r_cnt <= '0;
                end else if (w_rise[gc] && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign RISE_CNT[gc*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dig_ct_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dig_ct_lut_pipe
// Brief    : Bench for dig_ct_lut_pipe. Four instances (DEPTH 1/3/4 and a
//            2-bit counter variant) share one stimulus stream; a timestamped
//            scoreboard per instance plus fixed vector tables check them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dig_ct_lut_pipe;

    localparam logic [95:0] c_INIT = {32'hFFFFF0FF, 32'h3F3F3F3F, 32'hEFEFEFEF};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  in_bus;
    logic        in_vld;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_data;
    logic        cnt_clr;

    logic [2:0]  o1, o3, oc, o4;
    logic        v1, v3, vc, v4;
    logic [23:0] cnt1, cnt3, cnt4;
    logic [5:0]  cntc;

    dig_ct_lut_pipe u_d1 (
        .CLK(clk), .RST(rst), .IN(in_bus), .IN_VALID(in_vld), .CFG_WE(cfg_we),
        .CFG_SEL(cfg_sel), .CFG_DATA(cfg_data), .CNT_CLR(cnt_clr),
        .OUT(o1), .OUT_VALID(v1), .RISE_CNT(cnt1));

    dig_ct_lut_pipe #(.DEPTH(3)) u_d3 (
        .CLK(clk), .RST(rst), .IN(in_bus), .IN_VALID(in_vld), .CFG_WE(cfg_we),
        .CFG_SEL(cfg_sel), .CFG_DATA(cfg_data), .CNT_CLR(cnt_clr),
        .OUT(o3), .OUT_VALID(v3), .RISE_CNT(cnt3));

    dig_ct_lut_pipe #(.CNT_W(2)) u_c2 (
        .CLK(clk), .RST(rst), .IN(in_bus), .IN_VALID(in_vld), .CFG_WE(cfg_we),
        .CFG_SEL(cfg_sel), .CFG_DATA(cfg_data), .CNT_CLR(cnt_clr),
        .OUT(oc), .OUT_VALID(vc), .RISE_CNT(cntc));

    dig_ct_lut_pipe #(.DEPTH(4)) u_d4 (
        .CLK(clk), .RST(rst), .IN(in_bus), .IN_VALID(in_vld), .CFG_WE(cfg_we),
        .CFG_SEL(cfg_sel), .CFG_DATA(cfg_data), .CNT_CLR(cnt_clr),
        .OUT(o4), .OUT_VALID(v4), .RISE_CNT(cnt4));

    typedef struct packed {
        logic [2:0]  d;
        logic [31:0] k;
    } sb_t;

    typedef struct {
        logic [4:0] in;
        logic       vld;
        logic [2:0] eo;
        logic       ev;
        logic [7:0] c0, c1, c2;
    } vec_t;

    sb_t q0[$], q1[$], q2[$], q3[$];
    vec_t tbl[10];

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    logic [31:0] m_lut [3];
    logic [2:0]  m_out [4];
    int          m_cnt [4][3];
    int          depth_of [4] = '{1, 3, 1, 4};
    int          cmax     [4] = '{255, 255, 3, 255};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] lut_eval(input logic [4:0] a);
        logic [2:0] r;
        for (int c = 0; c < 3; c++) r[c] = m_lut[c][a];
        return r;
    endfunction

    function automatic logic [2:0] act_out(input int i);
        case (i)
            0:       return o1;
            1:       return o3;
            2:       return oc;
            default: return o4;
        endcase
    endfunction

    function automatic logic act_vld(input int i);
        case (i)
            0:       return v1;
            1:       return v3;
            2:       return vc;
            default: return v4;
        endcase
    endfunction

    function automatic logic [7:0] act_cnt(input int i, input int c);
        case (i)
            0:       return cnt1[c*8 +: 8];
            1:       return cnt3[c*8 +: 8];
            2:       return {6'b0, cntc[c*2 +: 2]};
            default: return cnt4[c*8 +: 8];
        endcase
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        for (int i = 0; i < 4; i++) begin
            m_out[i] = 3'b000;
            for (int c = 0; c < 3; c++) m_cnt[i][c] = 0;
        end
        for (int c = 0; c < 3; c++) m_lut[c] = c_INIT[c*32 +: 32];
    endtask

    // Pops the sample due this cycle (if any) and checks valid, data and counts
    task automatic sb_check(input int i);
        sb_t  f;
        logic ev;
        logic [2:0] nd;
        ev = 1'b0;
        f  = '0;
        case (i)
            0: if (q0.size() > 0 && q0[0].k + 32'(depth_of[i]) - 1 == cyc) begin ev = 1'b1; f = q0.pop_front(); end
            1: if (q1.size() > 0 && q1[0].k + 32'(depth_of[i]) - 1 == cyc) begin ev = 1'b1; f = q1.pop_front(); end
            2: if (q2.size() > 0 && q2[0].k + 32'(depth_of[i]) - 1 == cyc) begin ev = 1'b1; f = q2.pop_front(); end
            default: if (q3.size() > 0 && q3[0].k + 32'(depth_of[i]) - 1 == cyc) begin ev = 1'b1; f = q3.pop_front(); end
        endcase
        chk($sformatf("sb_vld%0d", i), 32'(act_vld(i)), 32'(ev));
        if (ev) begin
            nd = f.d;
            for (int c = 0; c < 3; c++) begin
                if (nd[c] && !m_out[i][c] && m_cnt[i][c] < cmax[i]) m_cnt[i][c]++;
            end
            m_out[i] = nd;
        end
        if (cnt_clr) begin
            for (int c = 0; c < 3; c++) m_cnt[i][c] = 0;
        end
        chk($sformatf("sb_out%0d", i), 32'(act_out(i)), 32'(m_out[i]));
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("sb_cnt%0d_%0d", i, c), 32'(act_cnt(i, c)), 32'(m_cnt[i][c]));
        end
    endtask

    // One clock: queue the expected result of a valid sample, then check
    task automatic step();
        sb_t s;
        if (in_vld) begin
            s.d = lut_eval(in_bus);
            s.k = cyc + 1;
            q0.push_back(s); q1.push_back(s); q2.push_back(s); q3.push_back(s);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cfg_we && cfg_sel < 2'd3) m_lut[cfg_sel] = cfg_data;
        for (int i = 0; i < 4; i++) sb_check(i);
    endtask

    task automatic check_zero(input string nm);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_out%0d", nm, i), 32'(act_out(i)), 32'd0);
            chk($sformatf("%s_vld%0d", nm, i), 32'(act_vld(i)), 32'd0);
            for (int c = 0; c < 3; c++)
                chk($sformatf("%s_cnt%0d_%0d", nm, i, c), 32'(act_cnt(i, c)), 32'd0);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear at once
    task automatic do_reset_async(input string nm);
        rst = 1'b1;
        #1;
        check_zero(nm);
        model_reset();
        in_vld = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_bus = '0; in_vld = 1'b0; cfg_we = 1'b0;
        cfg_sel = '0; cfg_data = '0; cnt_clr = 1'b0;
        model_reset();

        tbl[0] = '{5'd4,  1'b1, 3'b110, 1'b1, 8'd0, 8'd1, 8'd1};
        tbl[1] = '{5'd6,  1'b1, 3'b101, 1'b1, 8'd1, 8'd1, 8'd1};
        tbl[2] = '{5'd8,  1'b1, 3'b011, 1'b1, 8'd1, 8'd2, 8'd1};
        tbl[3] = '{5'd0,  1'b0, 3'b011, 1'b0, 8'd1, 8'd2, 8'd1};
        tbl[4] = '{5'd0,  1'b0, 3'b011, 1'b0, 8'd1, 8'd2, 8'd1};
        tbl[5] = '{5'd0,  1'b0, 3'b011, 1'b0, 8'd1, 8'd2, 8'd1};
        tbl[6] = '{5'd28, 1'b1, 3'b110, 1'b1, 8'd1, 8'd2, 8'd2};
        tbl[7] = '{5'd12, 1'b1, 3'b110, 1'b1, 8'd1, 8'd2, 8'd2};
        tbl[8] = '{5'd10, 1'b1, 3'b011, 1'b1, 8'd2, 8'd2, 8'd2};
        tbl[9] = '{5'd31, 1'b1, 3'b101, 1'b1, 8'd2, 8'd2, 8'd3};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        #2;
        rst = 1'b0;

        // Default functions, hold across bubbles, rise counts
        for (int n = 0; n < 10; n++) begin
            in_bus = tbl[n].in;
            in_vld = tbl[n].vld;
            step();
            chk($sformatf("tbl%0d_out", n), 32'(o1), 32'(tbl[n].eo));
            chk($sformatf("tbl%0d_vld", n), 32'(v1), 32'(tbl[n].ev));
            chk($sformatf("tbl%0d_cnt", n), 32'(cnt1), {8'd0, tbl[n].c2, tbl[n].c1, tbl[n].c0});
        end

        // DEPTH=3 latency of a lone sample
        in_vld = 1'b0;
        repeat (4) step();
        in_bus = 5'd4; in_vld = 1'b1;
        step();
        chk("d3_lat_e0", 32'(v3), 32'd0);
        in_vld = 1'b0;
        step();
        chk("d3_lat_e1", 32'(v3), 32'd0);
        step();
        chk("d3_lat_e2_vld", 32'(v3), 32'd1);
        chk("d3_lat_e2_out", 32'(o3), 32'(3'b110));
        step();
        chk("d3_lat_e3", 32'(v3), 32'd0);

        // Back-to-back samples with one bubble
        in_bus = 5'd6;  in_vld = 1'b1; step();
        in_bus = 5'd8;  in_vld = 1'b1; step();
        in_vld = 1'b0;                 step();
        in_bus = 5'd10; in_vld = 1'b1; step();
        in_vld = 1'b0;
        repeat (4) step();

        // Saturation of the 2-bit counter, then clear against a rise
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        in_vld = 1'b1;
        for (int n = 0; n < 5; n++) begin
            in_bus = 5'd4; step();
            in_bus = 5'd6; step();
        end
        chk("sat_c2_ch0", 32'(cntc[1:0]), 32'd3);
        chk("sat_d1_ch0", 32'(cnt1[7:0]), 32'd5);
        in_bus = 5'd4; step();
        in_bus = 5'd6; cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        chk("clr_c2_ch0", 32'(cntc[1:0]), 32'd0);
        chk("clr_d1_ch0", 32'(cnt1[7:0]), 32'd0);
        in_vld = 1'b0;
        repeat (4) step();

        // Reset mid-stream, then the first sample after release
        in_bus = 5'd8; in_vld = 1'b1; step();
        do_reset_async("mid");
        in_bus = 5'd4; in_vld = 1'b1; step();
        chk("post_rst_out", 32'(o1), 32'(3'b110));
        chk("post_rst_vld", 32'(v1), 32'd1);
        chk("post_rst_cnt", 32'(cnt1), 32'h00010100);

        // LUT write: same-edge sample uses old table, next sample the new one
        in_bus = 5'd0; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 32'h0; step();
        chk("cfg_old", 32'(o1[0]), 32'd1);
        cfg_we = 1'b0; step();
        chk("cfg_new", 32'(o1[0]), 32'd0);
        // Out-of-range select must not touch any table
        in_bus = 5'd6; cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 32'hFFFFFFFF; step();
        cfg_we = 1'b0; step();
        chk("cfg_sel3", 32'(o1), 32'(3'b100));
        in_vld = 1'b0;
        repeat (4) step();

        // Reset with three samples inside the DEPTH=4 pipe
        in_vld = 1'b1;
        in_bus = 5'd0; step();
        in_bus = 5'd6; step();
        in_bus = 5'd8; step();
        do_reset_async("pipe");
        for (int n = 0; n < 6; n++) begin
            step();
            chk($sformatf("flush_d4_%0d", n), 32'(v4), 32'd0);
        end
        in_bus = 5'd0; in_vld = 1'b1; step();
        chk("revert_d1", 32'(o1), 32'(3'b111));
        in_vld = 1'b0;
        repeat (3) step();
        chk("revert_d4_vld", 32'(v4), 32'd1);
        chk("revert_d4_out", 32'(o4), 32'(3'b111));
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dig_ct_lut_pipe.md
Name: dig_ct_lut_pipe

Overview:
- Multi-channel registered logic block with a programmable function per channel.
- Each channel evaluates a runtime-writable truth table (LUT) over a shared NIN-bit input bus.
- Results pass through a DEPTH-stage valid-qualified pipeline.
- Per-channel saturating counters count output rising edges.
- Default parameters and reset LUT contents reproduce the team's 3-output, 5-input registered gate circuit with 1-cycle latency. This block replaces it in the datapath.

Parameters:
- CH, 3, number of output channels (1..8)
- NIN, 5, input bus width; LUT size is 2**NIN bits (1..6)
- DEPTH, 1, pipeline stages from input sample to OUT (1..4)
- CNT_W, 8, width of each rising-edge counter
- LUT_INIT, {32'hFFFFF0FF, 32'h3F3F3F3F, 32'hEFEFEFEF}, CH*2**NIN bits; reset LUT contents, channel 0 in LSBs
- Localparam CSW = max(1, clog2(CH))

Ports:
- CLK  in  1  clock; all state changes on its rising edge
- RST  in  1  asynchronous, active-high reset
- IN  in  NIN  shared input bus; bit 0 = input 1
- IN_VALID  in  1  IN is sampled at this edge
- CFG_WE  in  1  LUT write strobe
- CFG_SEL  in  CSW  channel index to write
- CFG_DATA  in  2**NIN  new LUT contents
- CNT_CLR  in  1  synchronous clear of all counters
- OUT  out  CH  registered channel results
- OUT_VALID  out  1  OUT updated at the last edge (1-cycle pulse per sample)
- RISE_CNT  out  CH*CNT_W  per-channel rising-edge counts, channel 0 in LSBs

Behaviour:
- Reset (asynchronous, immediate, any time):
  - OUT=0, OUT_VALID=0, RISE_CNT=0.
  - All pipeline data and valid bits = 0; in-flight samples are discarded.
  - LUT[c] = LUT_INIT slice c.
- Function: f_c(IN) = LUT[c][IN], with IN used as an unsigned index.
- Stage 1 captures f_c(IN) for all channels and valid bit IN_VALID.
- Stages 2..DEPTH shift the valid bit every cycle.
  - A stage loads data only when its incoming valid bit is 1; otherwise its data holds.
- OUT is the final-stage data, so OUT holds across bubbles.
  - OUT_VALID is the final-stage valid bit.
- Latency: a sample taken at edge k appears on OUT/OUT_VALID after edge k+DEPTH-1.
  - With DEPTH=1 this is the same edge, matching the legacy circuit.
- Throughput: 1 sample per cycle, no backpressure.
- LUT write: at an edge with CFG_WE=1 and CFG_SEL<CH, LUT[CFG_SEL] <= CFG_DATA.
  - A sample captured at that same edge uses the old LUT; samples from the next edge use the new one.
  - CFG_SEL>=CH: write ignored, no side effect.
  - In-flight samples are not re-evaluated.
- Rising-edge counter, per channel c:
  - At an edge where the final stage loads and old OUT[c]=0, new OUT[c]=1: RISE_CNT[c] increments.
  - Saturates at 2**CNT_W-1; no wrap.
  - CNT_CLR=1 at an edge sets all counters to 0 and overrides a simultaneous increment.
  - Because OUT resets to 0, the first valid 1 after reset counts.
- No combinational path from any input to any output.

Test Plan:
- Reset, default params: assert RST mid-stream -> immediately OUT=3'b000, OUT_VALID=0, RISE_CNT=0. Release, then IN=5'b00100 with IN_VALID=1 -> after next edge OUT=3'b110, OUT_VALID=1, counts ch0=0, ch1=1, ch2=1.
- Default functions: IN=5'b00110 -> OUT=3'b101 (ch1 0); IN=5'b01000 -> OUT=3'b011 (ch1 rises, count 2). Then IN_VALID=0 for 3 cycles -> OUT holds 3'b011, OUT_VALID=0.
- DEPTH=3: single valid sample at edge k -> OUT_VALID high only after edge k+2. Back-to-back samples emerge in order, one per cycle; a bubble in the input produces exactly one OUT_VALID=0 cycle.
- Config: CFG_WE=1, CFG_SEL=0, CFG_DATA=0 on the same edge as sample IN=5'b00000 -> OUT[0]=1 (old LUT). Next sample -> OUT[0]=0. CFG_SEL=3 with CH=3 -> all LUTs unchanged.
- Counters with CNT_W=2: toggle ch0 output 0/1 five times -> RISE_CNT[0] sticks at 3. CNT_CLR on the same edge as a rise -> count 0.
- Reset mid-pipeline, DEPTH=4: assert RST with 3 samples in flight -> no OUT_VALID pulse afterwards, and the LUTs revert to LUT_INIT even after earlier writes.
